seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 194 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for a 4-digit common-anode 7-segment
//            display. Each digit gets a slot of SCAN_DIV clocks, and a frame
//            covers all four slots. Display inputs are captured into shadow
//            registers only at frame boundaries, so a frame never shows a mix
//            of old and new data.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SCAN_DIV   clock cycles per digit slot (>= 2)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   hexs       four hex digits, digit i = hexs[4i+3:4i], digit 0 rightmost
//   points     decimal point request per digit (1 = lit)
//   LEs        per-digit blank request (1 = dark)
//   lzb        leading-zero blanking enable
//   AN         digit anodes, active-low, at most one low
//   SEGMENT    segments, active-low, [0]=a .. [6]=g, [7]=dp
//   frame_done one-cycle pulse at each frame boundary
// ============================================================================
module seg7_scan_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  LEs,
    input  logic        lzb,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);

    localparam int                c_PRESC_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_PRESC_W-1:0] r_presc;
    logic [1:0]           r_idx;
    logic [15:0]          r_sh_hexs;
    logic [3:0]           r_sh_points;
    logic [3:0]           r_sh_les;
    logic                 r_sh_lzb;
    // Set during reset; marks the first cycle after release, in which the
    // shadow registers take their first load.
    logic                 r_init;
    logic                 r_frame_done;
    logic [3:0]           r_an;
    logic [7:0]           r_seg;

    // ------------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------------
    logic w_tick;
    logic w_wrap;
    logic w_load;

    assign w_tick = (r_presc == c_PRESC_MAX);
    assign w_wrap = w_tick && (r_idx == 2'd3);
    assign w_load = r_init || w_wrap;

    // ------------------------------------------------------------------------
    // Decode source. In the very first cycle after reset the shadow registers
    // are still zero while being loaded, so the decoder looks straight at the
    // inputs; that keeps the first slot of digit 0 correct for its full length.
    // At any other time only the shadow copy is used.
    // ------------------------------------------------------------------------
    logic [15:0] w_src_hexs;
    logic [3:0]  w_src_points;
    logic [3:0]  w_src_les;
    logic        w_src_lzb;

    assign w_src_hexs   = r_init ? hexs   : r_sh_hexs;
    assign w_src_points = r_init ? points : r_sh_points;
    assign w_src_les    = r_init ? LEs    : r_sh_les;
    assign w_src_lzb    = r_init ? lzb    : r_sh_lzb;

    // ------------------------------------------------------------------------
    // Leading-zero detection. A digit counts as "empty" when its value is 0 and
    // its decimal point is off; LEs deliberately play no part here. Digit i is
    // a leading zero when it and every digit to its left are empty. Digit 0 is
    // never a leading zero so a value of all zeros still shows "0".
    // ------------------------------------------------------------------------
    logic [3:0] w_empty;
    logic [3:0] w_lz;

    generate
        for (genvar j = 0; j < 4; j++) begin : g_empty
            assign w_empty[j] = (w_src_hexs[4*j +: 4] == 4'h0) && !w_src_points[j];
        end

        for (genvar j = 0; j < 4; j++) begin : g_lz
            if (j == 3) begin : g_top
                assign w_lz[j] = w_empty[j];
            end else if (j == 0) begin : g_units
                assign w_lz[j] = 1'b0;
            end else begin : g_mid
                assign w_lz[j] = w_empty[j] && w_lz[j+1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Segment decode for the active digit
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        seg = 7'h7F;
        case (val)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [3:0] w_digit;
    logic       w_blank;
    logic [3:0] w_an_nxt;
    logic [7:0] w_seg_nxt;

    assign w_digit = w_src_hexs[{r_idx, 2'b00} +: 4];
    assign w_blank = w_src_les[r_idx] || (w_src_lzb && w_lz[r_idx]);

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 8'hFF;
        if (!w_blank) begin
            w_an_nxt[r_idx] = 1'b0;
            w_seg_nxt       = {~w_src_points[r_idx], hex_to_seg(w_digit)};
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= 2'd0;
            r_sh_hexs    <= 16'h0000;
            r_sh_points  <= 4'h0;
            r_sh_les     <= 4'h0;
            r_sh_lzb     <= 1'b0;
            r_init       <= 1'b1;
            r_frame_done <= 1'b0;
            r_an         <= 4'b1111;
            r_seg        <= 8'hFF;
        end else begin
            r_presc <= w_tick ? '0 : (r_presc + c_PRESC_ONE);
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_load) begin
                r_sh_hexs   <= hexs;
                r_sh_points <= points;
                r_sh_les    <= LEs;
                r_sh_lzb    <= lzb;
            end
            r_init       <= 1'b0;
            // Pulses together with the shadow update and the return to digit 0.
            r_frame_done <= w_wrap;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
        end
    end

    assign AN         = r_an;
    assign SEGMENT    = r_seg;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver with SCAN_DIV=4.
//            Expected per-cycle display states are queued when inputs are
//            applied and compared as each frame is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int c_DIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  LEs;
    logic        lzb;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_done;

    seg7_scan_driver #(.SCAN_DIV(c_DIV)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .hexs       (hexs),
        .points     (points),
        .LEs        (LEs),
        .lzb        (lzb),
        .AN         (AN),
        .SEGMENT    (SEGMENT),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t q_exp[$];
    int   n_total = 0;
    int   n_bad   = 0;

    logic [6:0] c_seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Display state expected for digit d given the values latched for the frame.
    function automatic exp_t slot_exp(input logic [15:0] hx, input logic [3:0] pt,
                                      input logic [3:0] le, input logic lz,
                                      input int d, input logic fd);
        exp_t e;
        logic blank;
        logic all_empty;
        blank = le[d];
        if (lz && d >= 1) begin
            all_empty = 1'b1;
            for (int j = d; j < 4; j++) begin
                if (hx[4*j +: 4] != 4'h0 || pt[j]) all_empty = 1'b0;
            end
            if (all_empty) blank = 1'b1;
        end
        e.fd = fd;
        if (blank) begin
            e.an  = 4'b1111;
            e.seg = 8'hFF;
        end else begin
            e.an    = 4'b1111;
            e.an[d] = 1'b0;
            e.seg   = {~pt[d], c_seg_tab[hx[4*d +: 4]]};
        end
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] hx, input logic [3:0] pt,
                              input logic [3:0] le, input logic lz);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < c_DIV; c++) begin
                q_exp.push_back(slot_exp(hx, pt, le, lz, d, (d == 3) && (c == c_DIV - 1)));
            end
        end
    endtask

    // Advance to the next negedge at which frame_done is high.
    task automatic sync_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        if (!frame_done) chk("sync_fd_timeout", 32'd0, 32'd1);
    endtask

    // Starting at a frame boundary, observe one full frame. Optionally change
    // hexs after observation cycle chg_at.
    task automatic capture_frame(input string tag, input int chg_at, input logic [15:0] chg_hexs);
        exp_t e;
        for (int c = 0; c < 4 * c_DIV; c++) begin
            @(negedge clk);
            if (q_exp.size() == 0) begin
                chk({tag, " queue_empty"}, 32'd1, 32'd0);
            end else begin
                e = q_exp.pop_front();
                chk($sformatf("%s an c%0d", tag, c), {28'd0, AN}, {28'd0, e.an});
                chk($sformatf("%s seg c%0d", tag, c), {24'd0, SEGMENT}, {24'd0, e.seg});
                chk($sformatf("%s fd c%0d", tag, c), {31'd0, frame_done}, {31'd0, e.fd});
            end
            if (c == chg_at) hexs = chg_hexs;
        end
    endtask

    task automatic run(input string tag, input logic [15:0] hx, input logic [3:0] pt,
                       input logic [3:0] le, input logic lz);
        hexs = hx; points = pt; LEs = le; lzb = lz;
        sync_fd();
        push_frame(hx, pt, le, lz);
        capture_frame(tag, -1, 16'h0);
    endtask

    always @(negedge clk) begin
        assert ($countones(~AN) <= 1) else $error("more than one anode low: %b", AN);
    end

    initial begin
        rst = 1'b1; hexs = 16'h1234; points = 4'h0; LEs = 4'h0; lzb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst an", {28'd0, AN}, 32'hF);
        chk("rst seg", {24'd0, SEGMENT}, 32'hFF);
        chk("rst fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Plain digits, two consecutive frames to see the 16-cycle period.
        push_frame(16'h1234, 4'h0, 4'h0, 1'b0);
        capture_frame("basic0", -1, 16'h0);
        push_frame(16'h1234, 4'h0, 4'h0, 1'b0);
        capture_frame("basic1", -1, 16'h0);

        // Leading-zero blanking, then a decimal point stops blanking.
        run("lzb5", 16'h0005, 4'b0000, 4'h0, 1'b1);
        run("lzbdp", 16'h0005, 4'b0100, 4'h0, 1'b1);

        // Input change mid-frame only shows from the next frame.
        run("aaaa", 16'hAAAA, 4'h0, 4'h0, 1'b0);
        push_frame(16'hAAAA, 4'h0, 4'h0, 1'b0);
        capture_frame("midA", 5, 16'hBBBB);
        push_frame(16'hBBBB, 4'h0, 4'h0, 1'b0);
        capture_frame("nextB", -1, 16'h0);

        // Per-digit blanking.
        run("les", 16'h8888, 4'h0, 4'b1010, 1'b0);

        // Reset during digit 2, then a full restart at digit 0.
        run("prerst", 16'h1234, 4'b0001, 4'h0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst an", {28'd0, AN}, 32'hF);
        chk("midrst seg", {24'd0, SEGMENT}, 32'hFF);
        chk("midrst fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        push_frame(16'h1234, 4'b0001, 4'h0, 1'b0);
        capture_frame("postrst", -1, 16'h0);

        // All zeros with blanking: only digit 0 lit.
        run("zero", 16'h0000, 4'h0, 4'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
